// File: rtl/stream_decoder_pkg.sv
// Shared definitions for the stream decoder: default widths and FSM state encoding.
package stream_decoder_pkg;

  localparam int SEL_W_DEF = 2;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/stream_decoder_bin2onehot.sv
// Purely combinational binary-to-one-hot decode with an enable that forces all zeros.
module bin2onehot #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      code,
  input  logic                  en,
  output logic [(1<<SEL_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[code] = 1'b1;
  end

endmodule

// File: rtl/stream_decoder.sv
// Registered binary-to-one-hot decoder with a 2-entry skid buffer and delivered-word counter.
module stream_decoder
  import stream_decoder_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_code,
  input  logic                  in_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(1<<SEL_W)-1:0] out_onehot,
  output logic [SEL_W-1:0]      out_code,
  output logic [CNT_W-1:0]      out_count,
  output state_t                state
);

  localparam int DEC_W = 1 << SEL_W;

  // Handshake rule: a word moves only in a cycle where valid and ready are both
  // high at the rising edge; in_ready is a flop so it never follows out_ready.
  state_t             state_q, state_d;
  logic               in_ready_q;
  logic [DEC_W-1:0]   out_word_q, skid_word_q, in_word;
  logic [SEL_W-1:0]   out_code_q, skid_code_q;
  logic [CNT_W-1:0]   count_q;
  logic               accept, deliver;

  bin2onehot #(.SEL_W(SEL_W)) u_dec (
    .code   (in_code),
    .en     (in_en),
    .onehot (in_word)
  );

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !deliver)      state_d = ST_TWO;
        else if (!accept && deliver) state_d = ST_EMPTY;
      end
      ST_TWO:  if (deliver) state_d = ST_ONE;
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid  = (state_q != ST_EMPTY);
    in_ready   = in_ready_q;
    out_onehot = out_word_q;
    out_code   = out_code_q;
    out_count  = count_q;
    state      = state_q;
  end

  // Output register loads a fresh word when it is free or being vacated; the skid
  // register only captures when the output register is busy and stays busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word_q  <= '0;
      out_code_q  <= '0;
      skid_word_q <= '0;
      skid_code_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          out_word_q <= in_word;
          out_code_q <= in_code;
        end
        ST_ONE: begin
          if (accept && deliver) begin
            out_word_q <= in_word;
            out_code_q <= in_code;
          end else if (accept) begin
            skid_word_q <= in_word;
            skid_code_q <= in_code;
          end
        end
        ST_TWO: if (deliver) begin
          out_word_q <= skid_word_q;
          out_code_q <= skid_code_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       count_q <= '0;
    else if (deliver) count_q <= count_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_stream_decoder.sv
// Self-checking bench for stream_decoder: directed scenarios plus random traffic against a queue model.
module tb_stream_decoder;
  import stream_decoder_pkg::*;

  localparam int SEL_W = 2;
  localparam int CNT_W = 8;
  localparam int DEC_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SEL_W-1:0] in_code = '0;
  logic             in_en = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DEC_W-1:0] out_onehot;
  logic [SEL_W-1:0] out_code;
  logic [CNT_W-1:0] out_count;
  state_t           state;

  int tests  = 0;
  int failed = 0;

  // Model: exp_q holds {code, onehot} of every word inside the DUT, oldest first.
  logic [SEL_W+DEC_W-1:0] exp_q[$];
  int                     exp_count = 0;

  always #5 clk = ~clk;

  stream_decoder #(.SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_code   (out_code),
    .out_count  (out_count),
    .state      (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DEC_W-1:0] ref_word(input int code, input bit en);
    return en ? DEC_W'(1 << code) : '0;
  endfunction

  // Compare DUT outputs with the model; called mid-cycle (after negedge).
  task automatic check_outputs(input string tag);
    int occ = exp_q.size();
    check({tag, ".in_ready"},  32'(in_ready),  32'(occ < 2));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(occ > 0));
    check({tag, ".state"},     32'(state),     32'(occ));
    check({tag, ".count"},     32'(out_count), 32'(exp_count));
    if (occ > 0) begin
      check({tag, ".onehot"}, 32'(out_onehot), 32'(exp_q[0][DEC_W-1:0]));
      check({tag, ".code"},   32'(out_code),   32'(exp_q[0][SEL_W+DEC_W-1:DEC_W]));
    end
  endtask

  // One clock cycle: check, drive, advance model, clock.
  task automatic step(input string tag, input bit v, input int code, input bit en, input bit ordy);
    bit acc, dlv;
    check_outputs(tag);
    in_valid  = v;
    in_code   = SEL_W'(code);
    in_en     = en;
    out_ready = ordy;
    acc = v && (exp_q.size() < 2);
    dlv = ordy && (exp_q.size() > 0);
    if (dlv) begin
      void'(exp_q.pop_front());
      exp_count = (exp_count + 1) % (1 << CNT_W);
    end
    if (acc) exp_q.push_back({SEL_W'(code), ref_word(code, en)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    exp_count = 0;
    #1;
    check({tag, ".rst_valid"},  32'(out_valid),  32'(0));
    check({tag, ".rst_onehot"}, 32'(out_onehot), 32'(0));
    check({tag, ".rst_code"},   32'(out_code),   32'(0));
    check({tag, ".rst_ready"},  32'(in_ready),   32'(1));
    check({tag, ".rst_count"},  32'(out_count),  32'(0));
    check({tag, ".rst_state"},  32'(state),      32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset("reset");

    // Single word, code 2, enable high
    step("single", 1, 2, 1, 1);
    check("single.word", 32'(out_onehot), 32'h4);
    step("single", 0, 0, 0, 1);
    check("single.count", 32'(out_count), 32'd1);

    // Back-pressure: third push is refused while both registers hold words
    step("bp", 1, 0, 1, 0);
    step("bp", 1, 1, 1, 0);
    check("bp.full", 32'(in_ready), 32'd0);
    step("bp", 1, 2, 1, 0);
    check("bp.hold", 32'(out_onehot), 32'h1);
    step("bp", 1, 2, 1, 1);
    step("bp", 1, 2, 1, 1);
    step("bp", 0, 0, 0, 1);
    step("bp", 0, 0, 0, 1);

    // Enable low still produces a counted all-zero word
    step("en0", 1, 3, 0, 1);
    check("en0.word", 32'(out_onehot), 32'h0);
    step("en0", 0, 0, 0, 1);

    // Streaming across the counter wrap
    for (int i = 0; i < 300; i++) step("stream", 1, i % 4, 1, 1);
    step("stream", 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step("rand", $urandom_range(0, 1) == 1, $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);

    // Mid-operation reset from the two-word state
    step("mid", 1, 1, 1, 0);
    step("mid", 1, 3, 1, 0);
    check("mid.two", 32'(state), 32'(ST_TWO));
    do_reset("midrst");
    @(negedge clk);
    step("post", 1, 3, 1, 0);
    check("post.lat", 32'(out_valid), 32'd1);
    step("post", 0, 0, 0, 1);
    step("post", 0, 0, 0, 1);
    check_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
